// File: rtl/interval_timer_ctrl.sv
// Sequencer for an external T-flip-flop counter: clears it, gates its enable through a
// prescaler, and reports terminal count as a one-shot or auto-reload done pulse.
module interval_timer_ctrl #(
    parameter int WIDTH    = 8,
    parameter int PS_WIDTH = 4
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                start,
    input  logic                stop,
    input  logic                pause,
    input  logic                mode,
    input  logic [WIDTH-1:0]    term_count,
    input  logic [PS_WIDTH-1:0] prescale,
    input  logic [WIDTH-1:0]    count_in,
    output logic                ctr_enable,
    output logic                ctr_clear_n,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR  = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [PS_WIDTH-1:0] ps_cnt_reg, ps_cnt_next;
    logic [PS_WIDTH-1:0] ps_reg;
    logic [WIDTH-1:0]    tc_reg;
    logic                mode_reg;
    logic                done_reg, done_next;
    logic                launch;
    logic                tick;
    logic                terminal;

    assign launch   = (state_reg == IDLE) && start && !stop;
    assign tick     = (state_reg == RUN) && (ps_cnt_reg == ps_reg) && !pause;
    // >= rather than == so a count already beyond the target ends the run instead of wrapping
    assign terminal = tick && (count_in >= tc_reg);

    always_comb begin
        state_next  = state_reg;
        ps_cnt_next = ps_cnt_reg;
        done_next   = 1'b0;
        ctr_enable  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (launch) begin
                    state_next = CLR;
                end
            end
            CLR: begin
                ps_cnt_next = '0;
                state_next  = stop ? IDLE : RUN;
            end
            RUN: begin
                if (stop) begin
                    state_next = IDLE;
                end else begin
                    if (!pause) begin
                        ps_cnt_next = tick ? '0 : ps_cnt_reg + 1'b1;
                    end
                    if (terminal) begin
                        done_next  = 1'b1;
                        state_next = mode_reg ? CLR : IDLE;
                    end else if (tick) begin
                        ctr_enable = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_reg  <= IDLE;
            ps_cnt_reg <= '0;
            ps_reg     <= '0;
            tc_reg     <= '0;
            mode_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            ps_cnt_reg <= ps_cnt_next;
            done_reg   <= done_next;
            if (launch) begin
                tc_reg   <= term_count;
                ps_reg   <= prescale;
                mode_reg <= mode;
            end
        end
    end

    // The counter is held cleared during reset as well as for the CLR cycle.
    assign ctr_clear_n = !(clear || (state_reg == CLR));
    assign busy        = (state_reg != IDLE);
    assign done        = done_reg;

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Self-checking bench for interval_timer_ctrl with a behavioural counter and run model.
module tb_interval_timer_ctrl;

    logic       clock = 1'b0;
    logic       clear, start, stop, pause, mode;
    logic [7:0] term_count;
    logic [3:0] prescale;
    logic [7:0] count_in;
    logic       ctr_enable, ctr_clear_n, busy, done;

    logic [7:0] cnt_model;
    logic       override_en;
    logic [7:0] override_val;

    int tests = 0;
    int fails = 0;

    interval_timer_ctrl #(.WIDTH(8), .PS_WIDTH(4)) dut (
        .clock       (clock),
        .clear       (clear),
        .start       (start),
        .stop        (stop),
        .pause       (pause),
        .mode        (mode),
        .term_count  (term_count),
        .prescale    (prescale),
        .count_in    (count_in),
        .ctr_enable  (ctr_enable),
        .ctr_clear_n (ctr_clear_n),
        .busy        (busy),
        .done        (done)
    );

    always #5 clock = ~clock;

    // The external counter driven by the controller
    always @(posedge clock) begin
        if (!ctr_clear_n) cnt_model <= 8'd0;
        else if (ctr_enable) cnt_model <= cnt_model + 8'd1;
    end

    assign count_in = override_en ? override_val : cnt_model;

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_start(input logic [7:0] tc, input logic [3:0] ps, input logic m);
        term_count = tc;
        prescale   = ps;
        mode       = m;
        start      = 1'b1;
        step();
        start      = 1'b0;
    endtask

    task automatic test_reset();
        clear = 1'b1; start = 0; stop = 0; pause = 0; mode = 0;
        term_count = 0; prescale = 0; override_en = 0; override_val = 0;
        step();
        step();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0d expected 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %0d expected 0", done); end
        tests++; if (ctr_enable !== 1'b0) begin fails++; $display("FAIL reset_enable: got %0d expected 0", ctr_enable); end
        tests++; if (ctr_clear_n !== 1'b0) begin fails++; $display("FAIL reset_clear_n: got %0d expected 0", ctr_clear_n); end
        clear = 1'b0;
        #1;
        tests++; if (ctr_clear_n !== 1'b1) begin fails++; $display("FAIL release_clear_n: got %0d expected 1", ctr_clear_n); end
        step();
        tests++; if (count_in !== 8'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", count_in); end
        $display("[TB] reset done");
    endtask

    task automatic test_one_shot();
        int en_cnt = 0;
        int done_k = -1;
        int done_n = 0;
        do_start(8'd3, 4'd0, 1'b0);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL oneshot_busy: got %0d expected 1", busy); end
        tests++; if (ctr_clear_n !== 1'b0) begin fails++; $display("FAIL oneshot_clr: got %0d expected 0", ctr_clear_n); end
        // fields changing mid-run must be ignored
        term_count = 8'd200; prescale = 4'd9; mode = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (done) begin done_n++; if (done_k < 0) done_k = k; end
            if (ctr_enable) en_cnt++;
            step();
        end
        tests++; if (done_k !== 5) begin fails++; $display("FAIL oneshot_done_cycle: got %0d expected 5", done_k); end
        tests++; if (done_n !== 1) begin fails++; $display("FAIL oneshot_done_count: got %0d expected 1", done_n); end
        tests++; if (en_cnt !== 3) begin fails++; $display("FAIL oneshot_enables: got %0d expected 3", en_cnt); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL oneshot_idle: got %0d expected 0", busy); end
        tests++; if (count_in !== 8'd3) begin fails++; $display("FAIL oneshot_hold: got %0d expected 3", count_in); end
        $display("[TB] one-shot tc=3 ps=0 done at cycle %0d", done_k);
    endtask

    task automatic test_auto_reload();
        int done_n = 0;
        int bad_n = 0;
        int clr_n = 0;
        do_start(8'd2, 4'd1, 1'b1);
        for (int k = 0; k < 28; k++) begin
            if (done) begin
                done_n++;
                if (k == 0 || (k % 7) != 0) bad_n++;
            end
            if (!ctr_clear_n) clr_n++;
            step();
        end
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL reload_done4: got %0d expected 1", done); end
        tests++; if (done_n !== 3) begin fails++; $display("FAIL reload_done_count: got %0d expected 3", done_n); end
        tests++; if (bad_n !== 0) begin fails++; $display("FAIL reload_done_spacing: got %0d misplaced expected 0", bad_n); end
        tests++; if (clr_n !== 4) begin fails++; $display("FAIL reload_clears: got %0d expected 4", clr_n); end
        stop = 1'b1;
        step();
        stop = 1'b0;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reload_stop: got %0d expected 0", busy); end
        $display("[TB] auto-reload tc=2 ps=1 pulses=%0d", done_n + 1);
    endtask

    task automatic test_pause();
        int pause_left = 0;
        bit pause_started = 0;
        int done_k = -1;
        do_start(8'd10, 4'd0, 1'b0);
        for (int k = 0; k < 40; k++) begin
            if (done && done_k < 0) done_k = k;
            if (!pause_started && count_in == 8'd4) begin pause_started = 1; pause_left = 5; end
            pause = (pause_left > 0);
            #1;
            if (pause) begin
                tests++;
                if (ctr_enable !== 1'b0 || count_in !== 8'd4) begin
                    fails++; $display("FAIL pause_freeze: got en=%0d count=%0d expected en=0 count=4", ctr_enable, count_in);
                end
            end
            if (pause_left > 0) pause_left--;
            step();
        end
        pause = 1'b0;
        tests++; if (done_k !== 17) begin fails++; $display("FAIL pause_done_cycle: got %0d expected 17", done_k); end
        tests++; if (count_in !== 8'd10) begin fails++; $display("FAIL pause_final: got %0d expected 10", count_in); end
        $display("[TB] pause 5 cycles done at cycle %0d", done_k);
    endtask

    task automatic test_stop();
        bit hit = 0;
        int done_n = 0;
        do_start(8'd10, 4'd0, 1'b0);
        for (int k = 0; k < 30 && !hit; k++) begin
            if (count_in == 8'd6) hit = 1;
            else step();
        end
        tests++;
        if (!hit) begin
            fails++; $display("FAIL stop_reach6: got count %0d expected 6", count_in);
        end else begin
            stop = 1'b1;
            #1;
            tests++; if (ctr_enable !== 1'b0) begin fails++; $display("FAIL stop_enable: got %0d expected 0", ctr_enable); end
            step();
            stop = 1'b0;
            tests++; if (busy !== 1'b0) begin fails++; $display("FAIL stop_idle: got %0d expected 0", busy); end
            for (int k = 0; k < 4; k++) begin
                if (done) done_n++;
                step();
            end
            tests++; if (done_n !== 0) begin fails++; $display("FAIL stop_no_done: got %0d expected 0", done_n); end
            tests++; if (count_in !== 8'd6) begin fails++; $display("FAIL stop_hold: got %0d expected 6", count_in); end
        end
        $display("[TB] stop at count 6");
    endtask

    task automatic test_edges();
        int done_k = -1;
        int en_cnt = 0;
        logic [7:0] cnt_at_done = 8'd0;
        // tc = 0
        do_start(8'd0, 4'd0, 1'b0);
        step();
        tests++; if (done !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL tc0_run: got done=%0d busy=%0d expected 0 1", done, busy); end
        step();
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL tc0_done: got %0d expected 1", done); end
        tests++; if (count_in !== 8'd0) begin fails++; $display("FAIL tc0_count: got %0d expected 0", count_in); end
        step();
        // tc = 255, no wrap
        do_start(8'd255, 4'd0, 1'b0);
        for (int k = 0; k < 270; k++) begin
            if (done && done_k < 0) begin done_k = k; cnt_at_done = count_in; end
            step();
        end
        tests++; if (done_k !== 257) begin fails++; $display("FAIL tc255_cycle: got %0d expected 257", done_k); end
        tests++; if (cnt_at_done !== 8'd255) begin fails++; $display("FAIL tc255_count: got %0d expected 255", cnt_at_done); end
        tests++; if (count_in !== 8'd255) begin fails++; $display("FAIL tc255_hold: got %0d expected 255", count_in); end
        // count already beyond target
        override_en = 1'b1; override_val = 8'd9; done_k = -1;
        do_start(8'd5, 4'd2, 1'b0);
        for (int k = 0; k < 8; k++) begin
            if (done && done_k < 0) done_k = k;
            if (ctr_enable) en_cnt++;
            step();
        end
        override_en = 1'b0;
        tests++; if (done_k !== 4) begin fails++; $display("FAIL past_tc_cycle: got %0d expected 4", done_k); end
        tests++; if (en_cnt !== 0) begin fails++; $display("FAIL past_tc_enables: got %0d expected 0", en_cnt); end
        // start and stop together
        start = 1'b1; stop = 1'b1;
        step();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL start_stop_1: got %0d expected 0", busy); end
        step();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL start_stop_2: got %0d expected 0", busy); end
        start = 1'b0; stop = 1'b0;
        step();
        $display("[TB] edge cases complete");
    endtask

    // Model: a run is one CLR cycle then (tc+1)*(ps+1) non-paused RUN cycles;
    // enables fall on every (ps+1)-th such cycle except the last, done follows the last.
    task automatic test_random();
        for (int r = 0; r < 30; r++) begin
            int tc, ps, m, periods, p_total, work, periods_done, k;
            bit stop_run, done_exp, done_nxt, en_exp;
            int mst, mnext;   // 0 idle, 1 clear, 2 run
            tc = ($urandom % 8 == 0) ? 255 : $urandom_range(0, 12);
            ps = $urandom_range(0, 3);
            m  = $urandom_range(0, 1);
            periods  = m ? $urandom_range(1, 3) : 1;
            stop_run = ($urandom % 5 == 0);
            p_total  = (tc + 1) * (ps + 1);
            do_start(tc[7:0], ps[3:0], m[0]);
            mst = 1; work = 0; periods_done = 0; done_exp = 0; k = 0;
            forever begin
                tests++; if (busy !== (mst != 0)) begin fails++; $display("FAIL rnd_busy r%0d k%0d: got %0d expected %0d", r, k, busy, mst != 0); end
                tests++; if (done !== done_exp) begin fails++; $display("FAIL rnd_done r%0d k%0d: got %0d expected %0d", r, k, done, done_exp); end
                tests++; if (ctr_clear_n !== (mst != 1)) begin fails++; $display("FAIL rnd_clear_n r%0d k%0d: got %0d expected %0d", r, k, ctr_clear_n, mst != 1); end
                if (done_exp) begin
                    tests++; if (count_in !== tc[7:0]) begin fails++; $display("FAIL rnd_count r%0d: got %0d expected %0d", r, count_in, tc); end
                end
                if (mst == 0) break;
                if (k > 4000) begin
                    tests++; fails++; $display("FAIL rnd_timeout r%0d: got busy after %0d cycles expected idle", r, k);
                    break;
                end
                term_count = 8'($urandom); prescale = 4'($urandom); mode = 1'($urandom);
                start = ($urandom % 4 == 0);
                pause = ($urandom % 3 == 0);
                stop  = (stop_run && $urandom % 20 == 0) || (m == 1 && mst == 1 && periods_done >= periods);
                #1;
                done_nxt = 0; en_exp = 0; mnext = mst;
                if (mst == 1) begin
                    mnext = stop ? 0 : 2;
                    work  = 0;
                end else if (stop) begin
                    mnext = 0;
                end else if (!pause) begin
                    work++;
                    if (work == p_total) begin
                        done_nxt = 1; periods_done++;
                        mnext = m ? 1 : 0;
                    end else if (work % (ps + 1) == 0) begin
                        en_exp = 1;
                    end
                end
                tests++; if (ctr_enable !== en_exp) begin fails++; $display("FAIL rnd_enable r%0d k%0d: got %0d expected %0d", r, k, ctr_enable, en_exp); end
                step();
                mst = mnext; done_exp = done_nxt; k++;
            end
            start = 0; stop = 0; pause = 0;
            step();
            $display("[TB] random run %0d tc=%0d ps=%0d mode=%0d periods=%0d cycles=%0d", r, tc, ps, m, periods_done, k);
        end
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_pause();
        test_stop();
        test_edges();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
